// File: rtl/uvmt_cv32e40x_obi_arb_pkg.sv
// Shared types and constants for the testbench OBI memory arbiter.
package uvmt_cv32e40x_obi_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D} arb_state_t;
   typedef enum logic {ARB_ID_INSTR, ARB_ID_DATA} arb_id_t;

   localparam int ARB_MODE_RR        = 0;
   localparam int ARB_MODE_DATA_PRIO = 1;

endpackage

// File: rtl/uvmt_cv32e40x_obi_arb_id_fifo.sv
// Response-routing FIFO: remembers which requester owns each granted transaction, in grant order.
module uvmt_cv32e40x_obi_arb_id_fifo
   import uvmt_cv32e40x_obi_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    push_i,
   input  arb_id_t push_id_i,
   input  logic    pop_i,
   output logic    full_o,
   output logic    empty_o,
   output arb_id_t head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   arb_id_t          id_mem [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] cnt_q;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign head_o  = id_mem[rptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_i) wptr_q <= next_ptr(wptr_q);
         if (pop_i)  rptr_q <= next_ptr(rptr_q);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Payload storage carries no reset; only entries behind a nonzero count are ever read.
   always_ff @(posedge clk_i) begin
      if (push_i) id_mem[wptr_q] <= push_id_i;
   end

endmodule

// File: rtl/uvmt_cv32e40x_obi_mem_arbiter.sv
// Shares one OBI memory slave port between the instruction and data OBI masters.
// Optional build macro: UVMT_OBI_ARB_PARITY_CHK_EN enables the sticky reqpar checker.
module uvmt_cv32e40x_obi_mem_arbiter
   import uvmt_cv32e40x_obi_arb_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int ARB_MODE        = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              instr_req_i,
   input  logic [ADDR_W-1:0] instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic              instr_err_o,
   output logic [DATA_W-1:0] instr_rdata_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [3:0]        data_be_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              data_gnt_o,
   output logic              data_rvalid_o,
   output logic              data_err_o,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic              mem_err_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              instr_reqpar_i,
   input  logic              data_reqpar_i,
   output logic              instr_gntpar_o,
   output logic              data_gntpar_o,
   output logic              instr_rvalidpar_o,
   output logic              data_rvalidpar_o,
   output logic              par_err_o,
   output logic              orphan_rsp_o
);

   arb_state_t state_q, state_d;
   arb_id_t    last_winner_q;
   arb_id_t    winner;
   arb_id_t    sel_id;
   logic       sel_req;
   logic       fwd;
   logic       grant;
   logic       sel_data;
   logic       fifo_full, fifo_empty, rsp_ok;
   arb_id_t    fifo_head;

   // Fresh arbitration, used only while no requester holds the lock.
   always_comb begin
      winner = ARB_ID_INSTR;
      if (ARB_MODE == ARB_MODE_DATA_PRIO) begin
         if (data_req_i) winner = ARB_ID_DATA;
      end else if (instr_req_i && data_req_i) begin
         winner = (last_winner_q == ARB_ID_INSTR) ? ARB_ID_DATA : ARB_ID_INSTR;
      end else if (data_req_i) begin
         winner = ARB_ID_DATA;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_id  = winner;
      sel_req = instr_req_i | data_req_i;
      case (state_q)
         ARB_LOCK_I: begin
            sel_id  = ARB_ID_INSTR;
            sel_req = instr_req_i;
         end
         ARB_LOCK_D: begin
            sel_id  = ARB_ID_DATA;
            sel_req = data_req_i;
         end
         default: ;
      endcase
      // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
      fwd   = sel_req && !fifo_full && !rst_i;
      grant = fwd && mem_gnt_i;
      case (state_q)
         ARB_IDLE: begin
            if (fwd && !mem_gnt_i)
               state_d = (sel_id == ARB_ID_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
         end
         default: begin
            if (!sel_req || grant) state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ARB_IDLE;
         last_winner_q <= ARB_ID_INSTR;
      end else begin
         state_q <= state_d;
         if (grant) last_winner_q <= sel_id;
      end
   end

   assign sel_data    = (sel_id == ARB_ID_DATA);
   assign mem_req_o   = fwd;
   assign mem_we_o    = sel_data & data_we_i;
   assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
   assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
   assign mem_wdata_o = sel_data ? data_wdata_i : '0;

   assign instr_gnt_o    = grant && !sel_data;
   assign data_gnt_o     = grant &&  sel_data;
   assign instr_gntpar_o = ~instr_gnt_o;
   assign data_gntpar_o  = ~data_gnt_o;

   uvmt_cv32e40x_obi_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (grant),
      .push_id_i (sel_id),
      .pop_i     (rsp_ok),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .head_o    (fifo_head)
   );

   // Responses follow the FIFO head; with nothing outstanding they are dropped and flagged.
   assign rsp_ok       = mem_rvalid_i && !fifo_empty && !rst_i;
   assign orphan_rsp_o = mem_rvalid_i &&  fifo_empty && !rst_i;

   assign instr_rvalid_o = rsp_ok && (fifo_head == ARB_ID_INSTR);
   assign data_rvalid_o  = rsp_ok && (fifo_head == ARB_ID_DATA);
   assign instr_err_o    = instr_rvalid_o && mem_err_i;
   assign data_err_o     = data_rvalid_o  && mem_err_i;
   assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
   assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

   assign instr_rvalidpar_o = ~instr_rvalid_o;
   assign data_rvalidpar_o  = ~data_rvalid_o;

`ifdef UVMT_OBI_ARB_PARITY_CHK_EN
   logic par_err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         par_err_q <= 1'b0;
      end else if ((instr_reqpar_i == instr_req_i) || (data_reqpar_i == data_req_i)) begin
         par_err_q <= 1'b1;
      end
   end

   assign par_err_o = par_err_q;
`else
   logic unused_reqpar;

   assign unused_reqpar = instr_reqpar_i ^ data_reqpar_i;
   assign par_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_mem_arbiter.sv
// Directed scenarios plus a randomized run scored against a transaction-level arbiter model.
module tb_uvmt_cv32e40x_obi_mem_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MAX_OUT = 2;

   logic clk = 1'b0;
   logic rst;
   logic instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
   logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
   logic [3:0]  data_be;
   logic instr_par_inj, data_par_inj;
   logic instr_reqpar, data_reqpar;

   logic instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
   logic mem_req_o, mem_we_o;
   logic [3:0] mem_be_o;
   logic instr_gntpar_o, data_gntpar_o, instr_rvalidpar_o, data_rvalidpar_o;
   logic par_err_o, orphan_rsp_o;

   assign instr_reqpar = ~instr_req ^ instr_par_inj;
   assign data_reqpar  = ~data_req ^ data_par_inj;

   always #5 clk = ~clk;

   uvmt_cv32e40x_obi_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT), .ARB_MODE(0)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr), .data_be_i(data_be),
      .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
      .instr_reqpar_i(instr_reqpar), .data_reqpar_i(data_reqpar),
      .instr_gntpar_o(instr_gntpar_o), .data_gntpar_o(data_gntpar_o),
      .instr_rvalidpar_o(instr_rvalidpar_o), .data_rvalidpar_o(data_rvalidpar_o),
      .par_err_o(par_err_o), .orphan_rsp_o(orphan_rsp_o)
   );

   typedef struct {
      bit          port;   // 0 = instr, 1 = data
      logic [31:0] rdata;
      bit          err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mem_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   sb_en  = 1'b0;

   // Reference model: lock owner (0 none, 1 instr, 2 data), last granted port, outstanding count.
   int   m_lock;
   bit   m_last;
   int   m_cnt;
   bit   i_pend, d_pend, d_we_v;
   logic [31:0] i_addr_v, d_addr_v, d_wdata_v;
   logic [3:0]  d_be_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      instr_req = 0; instr_addr = '0; data_req = 0; data_we = 0; data_addr = '0;
      data_be = '0; data_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
      mem_rdata = '0; instr_par_inj = 0; data_par_inj = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      idle_inputs();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic monitor();
      rsp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_en && (mem_rvalid || instr_rvalid_o || data_rvalid_o)) begin
            chk("rsp present", instr_rvalid_o | data_rvalid_o, 1);
            chk("rsp onehot", instr_rvalid_o & data_rvalid_o, 0);
            chk("rsp expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rsp port", data_rvalid_o, e.port);
               chk("rsp rdata", e.port ? data_rdata_o : instr_rdata_o, e.rdata);
               chk("rsp err", e.port ? data_err_o : instr_err_o, e.err);
            end
         end
      end
   endtask

   task automatic rand_cycle(input bit allow_new);
      bit   send, ir, dr, have, w, exp_req, exp_gnt;
      rsp_t r;
      @(negedge clk);
      send = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
      if (send) begin
         r = mem_q.pop_front();
         mem_rvalid = 1; mem_rdata = r.rdata; mem_err = r.err;
      end else begin
         mem_rvalid = 0; mem_rdata = $urandom; mem_err = $urandom_range(0, 1);
      end
      if (!allow_new) begin
         i_pend = 0; d_pend = 0;
      end
      if (i_pend) begin
         if ($urandom_range(0, 31) == 0) i_pend = 0;
      end else if (allow_new && $urandom_range(0, 1) == 1) begin
         i_pend = 1; i_addr_v = $urandom;
      end
      if (d_pend) begin
         if ($urandom_range(0, 31) == 0) d_pend = 0;
      end else if (allow_new && $urandom_range(0, 1) == 1) begin
         d_pend = 1; d_addr_v = $urandom; d_we_v = $urandom_range(0, 1);
         d_be_v = 4'($urandom); d_wdata_v = $urandom;
      end
      instr_req = i_pend; instr_addr = i_addr_v;
      data_req = d_pend; data_addr = d_addr_v; data_we = d_we_v;
      data_be = d_be_v; data_wdata = d_wdata_v;
      mem_gnt = ($urandom_range(0, 3) != 0);
      #1;
      ir = instr_req; dr = data_req;
      if (m_lock == 1) begin
         have = ir; w = 0;
      end else if (m_lock == 2) begin
         have = dr; w = 1;
      end else begin
         have = ir || dr;
         w    = (ir && dr) ? !m_last : dr;
      end
      exp_req = have && (m_cnt < MAX_OUT);
      exp_gnt = exp_req && mem_gnt;
      chk("mem_req", mem_req_o, exp_req);
      chk("instr_gnt", instr_gnt_o, exp_gnt && !w);
      chk("data_gnt", data_gnt_o, exp_gnt && w);
      chk("instr_gntpar", instr_gntpar_o, !(exp_gnt && !w));
      chk("orphan", orphan_rsp_o, 0);
      chk("par_err", par_err_o, 0);
      if (exp_req) begin
         chk("mem_addr", mem_addr_o, w ? d_addr_v : i_addr_v);
         chk("mem_we", mem_we_o, w ? d_we_v : 1'b0);
         chk("mem_be", mem_be_o, w ? d_be_v : 4'hF);
         chk("mem_wdata", mem_wdata_o, w ? d_wdata_v : 32'h0);
      end
      if (exp_gnt) begin
         r.port = w; r.rdata = $urandom; r.err = ($urandom_range(0, 7) == 0);
         exp_q.push_back(r);
         mem_q.push_back(r);
         if (w) d_pend = 0; else i_pend = 0;
         m_last = w;
         m_lock = 0;
      end else if (m_lock != 0 && !have) begin
         m_lock = 0;
      end else if (m_lock == 0 && exp_req) begin
         m_lock = w ? 2 : 1;
      end
      m_cnt = m_cnt + (exp_gnt ? 1 : 0) - (send ? 1 : 0);
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      fork
         monitor();
      join_none

      // Instruction fetch granted in the request cycle, response two cycles later.
      do_reset();
      #1;
      chk("reset mem_req", mem_req_o, 0);
      chk("reset gntpar", {instr_gntpar_o, data_gntpar_o, instr_rvalidpar_o, data_rvalidpar_o}, 4'hF);
      @(negedge clk); instr_req = 1; instr_addr = 32'h80; mem_gnt = 1; #1;
      chk("t1 instr_gnt", instr_gnt_o, 1);
      chk("t1 data_gnt", data_gnt_o, 0);
      chk("t1 mem_addr", mem_addr_o, 32'h80);
      chk("t1 mem_be/we", {mem_be_o, mem_we_o}, 5'b11110);
      chk("t1 gntpar", instr_gntpar_o, 0);
      @(negedge clk); instr_req = 0; mem_gnt = 0;
      @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h00000013; #1;
      chk("t1 instr_rvalid", instr_rvalid_o, 1);
      chk("t1 instr_rdata", instr_rdata_o, 32'h00000013);
      chk("t1 data_rvalid", data_rvalid_o, 0);
      chk("t1 rvalidpar", instr_rvalidpar_o, 0);
      @(negedge clk); mem_rvalid = 0;

      // Both requesting after reset: data first, then instruction; responses in that order.
      do_reset();
      @(negedge clk); instr_req = 1; data_req = 1; instr_addr = 32'h100; data_addr = 32'h200; mem_gnt = 1; #1;
      chk("t2 first data_gnt", data_gnt_o, 1);
      chk("t2 first instr_gnt", instr_gnt_o, 0);
      @(negedge clk); #1;
      chk("t2 second instr_gnt", instr_gnt_o, 1);
      chk("t2 second data_gnt", data_gnt_o, 0);
      @(negedge clk); instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hD0; #1;
      chk("t2 rsp1 data", {data_rvalid_o, instr_rvalid_o}, 2'b10);
      @(negedge clk); mem_rdata = 32'hC0; #1;
      chk("t2 rsp2 instr", {data_rvalid_o, instr_rvalid_o}, 2'b01);
      chk("t2 rsp2 rdata", instr_rdata_o, 32'hC0);
      @(negedge clk); mem_rvalid = 0;

      // Data locked while the slave stalls; instruction waits, then takes the second slot.
      do_reset();
      @(negedge clk); data_req = 1; data_addr = 32'h1000; data_we = 1; data_be = 4'h3;
      data_wdata = 32'hA5A5; #1;
      chk("t4 mem_req", mem_req_o, 1);
      chk("t4 mem_we", mem_we_o, 1);
      chk("t4 data_gnt c0", data_gnt_o, 0);
      for (int c = 1; c < 3; c++) begin
         @(negedge clk); instr_req = 1; instr_addr = 32'h200; #1;
         chk("t4 instr_gnt locked", instr_gnt_o, 0);
         chk("t4 mem_addr locked", mem_addr_o, 32'h1000);
      end
      @(negedge clk); mem_gnt = 1; #1;
      chk("t4 data_gnt", data_gnt_o, 1);
      chk("t4 instr_gnt", instr_gnt_o, 0);
      chk("t4 mem_wdata", mem_wdata_o, 32'hA5A5);
      @(negedge clk); data_req = 0; #1;
      chk("t4 instr_gnt after", instr_gnt_o, 1);
      chk("t4 instr wdata", mem_wdata_o, 32'h0);

      // FIFO full: third request held off, including the cycle of the first response.
      @(negedge clk); instr_addr = 32'h204; #1;
      chk("t3 full mem_req", mem_req_o, 0);
      chk("t3 full instr_gnt", instr_gnt_o, 0);
      @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h11; mem_err = 1; #1;
      chk("t3 pop data_rvalid", data_rvalid_o, 1);
      chk("t3 pop data_err", data_err_o, 1);
      chk("t3 pop data_rdata", data_rdata_o, 32'h11);
      chk("t3 pop instr_rvalid", instr_rvalid_o, 0);
      chk("t3 pop mem_req", mem_req_o, 0);
      @(negedge clk); mem_rvalid = 0; mem_err = 0; #1;
      chk("t3 third instr_gnt", instr_gnt_o, 1);

      // Reset with two outstanding: later response is an orphan.
      @(negedge clk); rst = 1; instr_req = 1; mem_gnt = 1; mem_rvalid = 1; #1;
      chk("t5 rst instr_gnt", instr_gnt_o, 0);
      chk("t5 rst mem_req", mem_req_o, 0);
      chk("t5 rst rvalid", {instr_rvalid_o, data_rvalid_o, orphan_rsp_o}, 3'b000);
      chk("t5 rst par", {instr_gntpar_o, data_rvalidpar_o, par_err_o}, 3'b110);
      @(negedge clk); rst = 0; instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h22; #1;
      chk("t5 orphan", orphan_rsp_o, 1);
      chk("t5 no port rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
      @(negedge clk); mem_rvalid = 0; #1;
      chk("t5 orphan pulse end", orphan_rsp_o, 0);

      // Parity injection on the instruction request.
      do_reset();
      @(negedge clk); instr_req = 1; instr_par_inj = 1; #1;
      chk("t6 par_err same cycle", par_err_o, 0);
      @(negedge clk); instr_req = 0; instr_par_inj = 0; #1;
`ifdef UVMT_OBI_ARB_PARITY_CHK_EN
      chk("t6 par_err set", par_err_o, 1);
      @(negedge clk); #1;
      chk("t6 par_err sticky", par_err_o, 1);
      do_reset();
      #1;
      chk("t6 par_err cleared", par_err_o, 0);
`else
      chk("t6 par_err tied", par_err_o, 0);
      do_reset();
`endif

      // Randomized traffic against the model.
      do_reset();
      m_lock = 0; m_last = 0; m_cnt = 0;
      i_pend = 0; d_pend = 0; d_we_v = 0;
      i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0; d_be_v = '0;
      exp_q.delete(); mem_q.delete();
      sb_en = 1;
      for (int n = 0; n < 3000; n++) rand_cycle(1'b1);
      for (int k = 0; k < 200 && mem_q.size() > 0; k++) rand_cycle(1'b0);
      @(negedge clk);
      idle_inputs();
      #3;
      chk("drain mem_q", mem_q.size(), 0);
      chk("drain exp_q", exp_q.size(), 0);
      sb_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
